// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT   = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

    // The single counter has to cover both the hold phase and the ack watchdog.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned timeout);
        int unsigned span;
        span = (hold > timeout) ? hold : timeout;
        return 32'($clog2(span)) + 32'd1;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with synchronous clear, count enable and terminal-value compare.
// Saturates at all ones so it never wraps.
module rst_seq_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             at_term_c
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign at_term_c = (cnt == term);

endmodule

// File: rtl/rst_sequencer.sv
// Releases NUM_STAGES downstream reset domains in order, one ack at a time.
// Define RST_SEQ_WDOG_EN to add the per-stage ack watchdog and sticky err flag.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              soft_rst_req,
    input  logic [NUM_STAGES-1:0]             stage_ack,
    output logic [NUM_STAGES-1:0]             stage_rst,
    output logic [$clog2(NUM_STAGES):0]       cur_stage,
    output logic                              busy,
    output logic                              all_ready,
    output logic                              err
);

    localparam int unsigned CW    = $clog2(NUM_STAGES) + 1;
    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, ACK_TIMEOUT);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_STAGES - 1);
    localparam logic [CW-1:0] DONE_IDX = CW'(NUM_STAGES);

    state_t                  state_q;
    state_t                  state_d;
    logic [NUM_STAGES-1:0]   stage_rst_d;
    logic [CW-1:0]           cur_d;
    logic                    busy_d;
    logic                    all_ready_d;
    logic                    ack_sel_c;
    logic                    advance_c;
    logic                    tmr_clr;
    logic                    tmr_en;
    logic [CNT_W-1:0]        tmr_term;
    logic                    tmr_at_term;

    // Only the awaited stage's ack is considered.
    always_comb begin
        ack_sel_c = 1'b0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (cur_stage == CW'(k)) begin
                ack_sel_c = stage_ack[k];
            end
        end
    end

`ifdef RST_SEQ_WDOG_EN
    logic err_q;
    logic err_d;
    logic timeout_c;

    assign tmr_term  = (state_q == ASSERT) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(ACK_TIMEOUT - 1);
    assign timeout_c = (state_q == WAIT_ACK) && !ack_sel_c && tmr_at_term;
    assign advance_c = ack_sel_c || timeout_c;
    assign err       = err_q;
`else
    assign tmr_term  = CNT_W'(HOLD_CYCLES - 1);
    assign advance_c = ack_sel_c;
    assign err       = 1'b0;
`endif

    rst_seq_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .term      (tmr_term),
        .at_term_c (tmr_at_term)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ASSERT;
            stage_rst <= '1;
            cur_stage <= '0;
            busy      <= 1'b1;
            all_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_rst <= stage_rst_d;
            cur_stage <= cur_d;
            busy      <= busy_d;
            all_ready <= all_ready_d;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    // Sticky: survives soft requests, only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (soft_rst_req) begin
            state_d = ASSERT;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (tmr_at_term) begin
                        state_d = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (advance_c && (cur_stage == LAST_IDX)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase
        end
    end

    // Output next values and timer control.
    always_comb begin
        stage_rst_d = stage_rst;
        cur_d       = cur_stage;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
`ifdef RST_SEQ_WDOG_EN
        err_d       = err_q || timeout_c;
`endif
        if (soft_rst_req) begin
            stage_rst_d = '1;
            cur_d       = '0;
            tmr_clr     = 1'b1;
        end else begin
            case (state_q)
                ASSERT: begin
                    stage_rst_d = '1;
                    tmr_en      = 1'b1;
                    if (tmr_at_term) begin
                        stage_rst_d[0] = 1'b0;
                        cur_d          = '0;
                        tmr_clr        = 1'b1;
                    end
                end
                WAIT_ACK: begin
`ifdef RST_SEQ_WDOG_EN
                    tmr_en = 1'b1;
`endif
                    if (advance_c) begin
                        tmr_clr = 1'b1;
                        if (cur_stage == LAST_IDX) begin
                            cur_d = DONE_IDX;
                        end else begin
                            cur_d = cur_stage + CW'(1);
                            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                                if (cur_stage + CW'(1) == CW'(k)) begin
                                    stage_rst_d[k] = 1'b0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    tmr_en = 1'b0;
                end
            endcase
        end
        busy_d      = (state_d != DONE);
        all_ready_d = (state_d == DONE);
    end

endmodule
